// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS control tokens, alignment FSM states and default limits
package tmds_pkg;

  localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

  localparam int DEF_TOKEN_RUN      = 8;
  localparam int DEF_SEARCH_TIMEOUT = 4096;
  localparam int DEF_SLIP_SETTLE    = 16;
  localparam int DEF_LOCK_LOSS      = 4096;

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_SLIP,
    ST_WAIT,
    ST_LOCKED
  } align_state_t;

  // Returns {hit, C1, C0} for a raw channel word.
  function automatic logic [2:0] token_match(input logic [9:0] w);
    logic [2:0] r;
    r = 3'b000;
    case (w)
      TOKEN_C00: r = 3'b100;
      TOKEN_C01: r = 3'b101;
      TOKEN_C10: r = 3'b110;
      TOKEN_C11: r = 3'b111;
      default:   r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tmds_align_fsm.sv
// rtl/tmds_align_fsm.sv - word-alignment FSM: token run counter, timers, bitslip request and lock flag
module tmds_align_fsm
  import tmds_pkg::*;
#(
  parameter int TOKEN_RUN      = DEF_TOKEN_RUN,
  parameter int SEARCH_TIMEOUT = DEF_SEARCH_TIMEOUT,
  parameter int SLIP_SETTLE    = DEF_SLIP_SETTLE,
  parameter int LOCK_LOSS      = DEF_LOCK_LOSS
) (
  input  logic PixelClk,
  input  logic aRst_n,
  input  logic is_token,
  output logic pBitslip,
  output logic pAligned
);

  localparam int TMAX_A    = (SEARCH_TIMEOUT > LOCK_LOSS) ? SEARCH_TIMEOUT : LOCK_LOSS;
  localparam int TIMER_MAX = (TMAX_A > SLIP_SETTLE) ? TMAX_A : SLIP_SETTLE;
  localparam int TW        = $clog2(TIMER_MAX) + 1;
  localparam int RW        = $clog2(TOKEN_RUN) + 1;

  align_state_t  state;
  logic [TW-1:0] timer;
  logic [RW-1:0] run_cnt;
  logic [RW-1:0] run_next;

  always_comb begin
    run_next = '0;
    if (is_token)
      run_next = (run_cnt == RW'(TOKEN_RUN)) ? run_cnt : run_cnt + 1'b1;
  end

  // A single timer serves search timeout, settle wait and lock loss; it clears on every state change.
  always_ff @(posedge PixelClk or negedge aRst_n) begin
    if (!aRst_n) begin
      state    <= ST_SEARCH;
      timer    <= '0;
      run_cnt  <= '0;
      pBitslip <= 1'b0;
      pAligned <= 1'b0;
    end else begin
      pBitslip <= 1'b0;
      run_cnt  <= run_next;
      case (state)
        ST_SEARCH: begin
          if (run_next == RW'(TOKEN_RUN)) begin
            state    <= ST_LOCKED;
            timer    <= '0;
            run_cnt  <= '0;
            pAligned <= 1'b1;
          end else if (timer == TW'(SEARCH_TIMEOUT - 1)) begin
            state    <= ST_SLIP;
            timer    <= '0;
            run_cnt  <= '0;
            pBitslip <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_SLIP: begin
          state   <= ST_WAIT;
          timer   <= '0;
          run_cnt <= '0;
        end
        ST_WAIT: begin
          if (timer == TW'(SLIP_SETTLE - 1)) begin
            state   <= ST_SEARCH;
            timer   <= '0;
            run_cnt <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (is_token) begin
            timer <= '0;
          end else if (timer == TW'(LOCK_LOSS - 1)) begin
            state    <= ST_SEARCH;
            timer    <= '0;
            run_cnt  <= '0;
            pAligned <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= ST_SEARCH;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/tmds_decoder.sv
// rtl/tmds_decoder.sv - TMDS channel decoder with token-based word alignment
// Optional running-disparity checker enabled by TMDS_DECODER_DISP_CHECK_EN.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int TOKEN_RUN      = DEF_TOKEN_RUN,
  parameter int SEARCH_TIMEOUT = DEF_SEARCH_TIMEOUT,
  parameter int SLIP_SETTLE    = DEF_SLIP_SETTLE,
  parameter int LOCK_LOSS      = DEF_LOCK_LOSS
) (
  input  logic        PixelClk,
  input  logic        aRst_n,
  input  logic [9:0]  pDataInRaw,
  output logic [7:0]  pDataOut,
  output logic        pC0,
  output logic        pC1,
  output logic        pVde,
  output logic        pBitslip,
  output logic        pAligned
`ifdef TMDS_DECODER_DISP_CHECK_EN
  ,
  output logic        pDispErr,
  output logic [15:0] pErrCnt
`endif
);

  logic [9:0] raw_q;
  logic       tok_q;
  logic [1:0] code_q;
  logic [7:0] d;
  logic [7:0] dec;

  always_ff @(posedge PixelClk or negedge aRst_n) begin
    if (!aRst_n) begin
      raw_q  <= '0;
      tok_q  <= 1'b0;
      code_q <= '0;
    end else begin
      raw_q             <= pDataInRaw;
      {tok_q, code_q}   <= token_match(pDataInRaw);
    end
  end

  always_comb begin
    dec    = '0;
    d      = raw_q[9] ? ~raw_q[7:0] : raw_q[7:0];
    dec[0] = d[0];
    for (int i = 1; i < 8; i++)
      dec[i] = raw_q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
  end

  // Video is gated until alignment locks; control bits keep tracking tokens regardless.
  always_ff @(posedge PixelClk or negedge aRst_n) begin
    if (!aRst_n) begin
      pDataOut <= '0;
      pVde     <= 1'b0;
      pC0      <= 1'b0;
      pC1      <= 1'b0;
    end else if (tok_q) begin
      pDataOut   <= '0;
      pVde       <= 1'b0;
      {pC1, pC0} <= code_q;
    end else begin
      pVde     <= pAligned;
      pDataOut <= pAligned ? dec : '0;
    end
  end

  tmds_align_fsm #(
    .TOKEN_RUN      (TOKEN_RUN),
    .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
    .SLIP_SETTLE    (SLIP_SETTLE),
    .LOCK_LOSS      (LOCK_LOSS)
  ) u_align (
    .PixelClk (PixelClk),
    .aRst_n   (aRst_n),
    .is_token (tok_q),
    .pBitslip (pBitslip),
    .pAligned (pAligned)
  );

`ifdef TMDS_DECODER_DISP_CHECK_EN
  logic signed [5:0] disp;
  logic [6:0]        disp_sum;
  logic signed [5:0] disp_sat;
  logic              over_new;
  logic              over_old;

  // Accumulator saturates rather than wraps so a long excursion stays flagged as out of range.
  always_comb begin
    disp_sum = {disp[5], disp} + {2'b00, 4'($countones(raw_q)), 1'b0} - 7'd10;
    if ($signed(disp_sum) > 7'sd31)
      disp_sat = 6'b011111;
    else if ($signed(disp_sum) < -7'sd32)
      disp_sat = 6'b100000;
    else
      disp_sat = disp_sum[5:0];
    over_new = (disp_sat > 6'sd10) || (disp_sat < -6'sd10);
    over_old = (disp > 6'sd10) || (disp < -6'sd10);
  end

  always_ff @(posedge PixelClk or negedge aRst_n) begin
    if (!aRst_n) begin
      disp     <= '0;
      pDispErr <= 1'b0;
      pErrCnt  <= '0;
    end else begin
      pDispErr <= 1'b0;
      if (tok_q) begin
        disp <= '0;
      end else if (pAligned) begin
        disp <= disp_sat;
        if (over_new && !over_old) begin
          pDispErr <= 1'b1;
          if (pErrCnt != 16'hFFFF)
            pErrCnt <= pErrCnt + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// tb/tb_tmds_decoder.sv - self-checking bench for tmds_decoder with a reference decode/alignment model
module tb_tmds_decoder;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  logic        PixelClk = 1'b0;
  logic        aRst_n = 1'b0;
  logic [9:0]  pDataInRaw = '0;
  logic [7:0]  pDataOut;
  logic        pC0, pC1, pVde, pBitslip, pAligned;
`ifdef TMDS_DECODER_DISP_CHECK_EN
  logic        pDispErr;
  logic [15:0] pErrCnt;
`endif

  int n_err = 0;
  int n_chk = 0;
  bit chk_al = 1'b1;
  int dec_tab [512];

  always #5 PixelClk = ~PixelClk;

  tmds_decoder dut (
    .PixelClk   (PixelClk),
    .aRst_n     (aRst_n),
    .pDataInRaw (pDataInRaw),
    .pDataOut   (pDataOut),
    .pC0        (pC0),
    .pC1        (pC1),
    .pVde       (pVde),
    .pBitslip   (pBitslip),
    .pAligned   (pAligned)
`ifdef TMDS_DECODER_DISP_CHECK_EN
    ,
    .pDispErr   (pDispErr),
    .pErrCnt    (pErrCnt)
`endif
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Encoder stage 1: transition-minimised 9-bit code.
  function automatic logic [8:0] tmds_qm(input logic [7:0] v);
    logic [8:0] q;
    int n1;
    bit use_xnor;
    n1 = $countones(v);
    use_xnor = (n1 > 4) || (n1 == 4 && v[0] == 1'b0);
    q[0] = v[0];
    for (int i = 1; i < 8; i++)
      q[i] = use_xnor ? ~(q[i-1] ^ v[i]) : (q[i-1] ^ v[i]);
    q[8] = ~use_xnor;
    return q;
  endfunction

  function automatic logic [9:0] enc_pos(input logic [7:0] v);
    logic [8:0] q;
    q = tmds_qm(v);
    return {1'b0, q[8], q[7:0]};
  endfunction

  function automatic logic [9:0] enc_neg(input logic [7:0] v);
    logic [8:0] q;
    q = tmds_qm(v);
    return {1'b1, q[8], ~q[7:0]};
  endfunction

  function automatic logic [2:0] ref_token(input logic [9:0] w);
    if (w == T00) return 3'b100;
    if (w == T01) return 3'b101;
    if (w == T10) return 3'b110;
    if (w == T11) return 3'b111;
    return 3'b000;
  endfunction

  function automatic logic [9:0] rotl(input logic [9:0] w, input int n);
    logic [19:0] x;
    x = {w, w} << n;
    return x[19:10];
  endfunction

  task automatic send(input logic [9:0] w);
    @(negedge PixelClk);
    pDataInRaw = w;
  endtask

  // Input history: w2 is the word whose decoded result is currently on the outputs.
  logic [9:0] w1, w2;
  always @(posedge PixelClk or negedge aRst_n) begin
    if (!aRst_n) begin
      w1 <= '0;
      w2 <= '0;
    end else begin
      w1 <= pDataInRaw;
      w2 <= w1;
    end
  end

  initial begin : compare
    int run, quiet, idx;
    bit al, prev_al, exp_vde, prev_slip;
    logic [1:0] mc;
    logic [2:0] tk;
    logic [8:0] qk;
    logic [7:0] exp_d;
    run = 0; quiet = 0; al = 0; mc = 2'b00; prev_slip = 0;
    forever begin
      @(posedge PixelClk);
      #2;
      if (!aRst_n) begin
        run = 0; quiet = 0; al = 0; mc = 2'b00; prev_slip = 0;
      end else begin
        prev_al = al;
        tk = ref_token(w2);
        if (tk[2]) begin
          mc = tk[1:0];
          quiet = 0;
          if (run < 8) run++;
          if (run == 8) al = 1;
        end else begin
          run = 0;
          quiet++;
          if (quiet >= 4096) al = 0;
        end
        exp_vde = !tk[2] && prev_al;
        exp_d = 8'h00;
        if (exp_vde) begin
          qk = {w2[8], w2[9] ? ~w2[7:0] : w2[7:0]};
          idx = dec_tab[qk];
          if (idx < 0) begin
            n_chk++; n_err++;
            $display("FAIL model_word: raw %0h is not a data word while aligned", w2);
          end else begin
            exp_d = 8'(idx);
          end
        end
        check("cyc_vde", 16'(pVde), 16'(exp_vde));
        check("cyc_data", 16'(pDataOut), 16'(exp_d));
        check("cyc_c", 16'({pC1, pC0}), 16'(mc));
        if (chk_al) begin
          check("cyc_aligned", 16'(pAligned), 16'(al));
          check("cyc_bitslip", 16'(pBitslip), 16'h0);
        end
        if (prev_slip) check("slip_back_to_back", 16'(pBitslip), 16'h0);
        prev_slip = pBitslip;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $finish;
  end

  initial begin : stim
    int off, slips, last, min_gap, cyc, pulses;
    bit got;
    for (int i = 0; i < 512; i++) dec_tab[i] = -1;
    for (int v = 0; v < 256; v++) dec_tab[tmds_qm(8'(v))] = v;

    // Reset held with random input: everything stays at zero.
    aRst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send(10'($urandom));
      #1;
      check("rst_data", 16'(pDataOut), 16'h0);
      check("rst_flags", 16'({pVde, pC1, pC0, pBitslip, pAligned}), 16'h0);
    end
    @(negedge PixelClk);
    aRst_n = 1'b1;
    for (int i = 0; i < 10; i++) send(10'($urandom));

    // Lock on a clean token run.
    for (int i = 0; i < 8; i++) send(T00);
    got = 0;
    for (int i = 0; i < 3 && !got; i++) begin
      send(T00);
      got = pAligned;
    end
    check("lock_after_run", 16'(got), 16'h1);

`ifdef TMDS_DECODER_DISP_CHECK_EN
    send(T00);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      send(10'b0011111111);
      pulses += int'(pDispErr);
    end
    for (int i = 0; i < 4; i++) begin
      send(T00);
      pulses += int'(pDispErr);
    end
    check("disp_err_pulses", 16'(pulses), 16'h1);
    check("disp_err_cnt", pErrCnt, 16'h1);
`endif

    // Post-lock token, then exact 2-cycle latency on following video.
    send(T11);
    send(12'h200);
    send(12'h200);
    check("tok_vde", 16'(pVde), 16'h0);
    check("tok_c", 16'({pC1, pC0}), 16'h3);
    check("tok_data", 16'(pDataOut), 16'h0);
    send(12'h200);
    check("lat_data_ff", 16'(pDataOut), 16'hFF);
    check("lat_vde", 16'(pVde), 16'h1);
    check("c_hold", 16'({pC1, pC0}), 16'h3);

    // Hand-encoded words pin the reference decode.
    begin
      logic [9:0] lw [6];
      logic [7:0] lv [6];
      lw = '{10'h100, 10'h3FF, 10'h200, 10'h133, 10'h3CC, 10'h163};
      lv = '{8'h00, 8'h00, 8'hFF, 8'h55, 8'h55, 8'hA5};
      for (int k = 0; k < 6; k++) begin
        send(lw[k]); send(lw[k]); send(lw[k]);
        check("literal_decode", 16'(pDataOut), 16'(lv[k]));
        check("literal_vde", 16'(pVde), 16'h1);
      end
    end

    for (int v = 0; v < 256; v++) begin
      send(enc_pos(8'(v)));
      send(enc_neg(8'(v)));
    end
    send(T01); send(T10); send(T00);

    // Misaligned stream: deserializer model rotates back one bit per bitslip.
    @(negedge PixelClk);
    aRst_n = 1'b0;
    @(negedge PixelClk);
    aRst_n = 1'b1;
    chk_al = 0;
    off = 3; slips = 0; last = -1; min_gap = 1000000; cyc = 0;
    while (!pAligned && cyc < 20000) begin
      send(rotl(T00, off));
      cyc++;
      if (pBitslip) begin
        slips++;
        if (last >= 0 && (cyc - last) < min_gap) min_gap = cyc - last;
        last = cyc;
        if (off > 0) off--;
      end
    end
    check("misalign_locked", 16'(pAligned), 16'h1);
    check("misalign_slips", 16'(slips), 16'h3);
    check("misalign_offset", 16'(off), 16'h0);
    check("misalign_gap_ok", 16'(min_gap >= 17), 16'h1);
    send(T00); send(T00); send(T00);
    chk_al = 1;
    send(T00);

    // Lock loss after 4096 consecutive video words.
    for (int i = 0; i < 4096; i++) send(enc_pos(8'(i)));
    send(enc_pos(8'h11));
    check("loss_hold", 16'(pAligned), 16'h1);
    send(enc_pos(8'h22));
    check("loss_drop", 16'(pAligned), 16'h0);
    check("loss_no_slip", 16'(pBitslip), 16'h0);

    // Reset asserted during the SLIP cycle drops the request immediately.
    chk_al = 0;
    got = 0;
    for (int i = 0; i < 5000 && !got; i++) begin
      send(enc_pos(8'(i)));
      got = pBitslip;
    end
    check("slip_reached", 16'(got), 16'h1);
    aRst_n = 1'b0;
    #1;
    check("rst_slip_drop", 16'(pBitslip), 16'h0);
    check("rst_mid_flags", 16'({pVde, pC1, pC0, pAligned}), 16'h0);
    check("rst_mid_data", 16'(pDataOut), 16'h0);
    send(T00); send(T00);
    @(negedge PixelClk);
    aRst_n = 1'b1;
    send(T00); send(T00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
